// File: rtl/sha256_round_engine.sv
// SHA-256 compression core: 16-word message window, one round per cycle, two-phase block toggle to H bank.
// Optional `SHA256_WRITE_GUARD_EN drops message writes while busy and flags them on wr_err.
module sha256_round_engine #(
  parameter int ROUNDS    = 64,
  parameter int LOAD_WAIT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         msg_we,
  input  logic [3:0]   msg_addr,
  input  logic [31:0]  msg_data,
  input  logic         start,
  input  logic [255:0] h_in,
  output logic         block,
  output logic [255:0] work_out,
  output logic         busy,
  output logic         done,
  output logic         wr_err
);

  // state | meaning
  // IDLE  | waiting for start
  // TOG1  | first block toggle, H bank reloads IV
  // WAIT  | LOAD_WAIT cycles for the IV to settle on h_in
  // LOAD  | a..h <= h_in
  // ROUND | one compression round per cycle
  // FIN   | second block toggle (accumulate), done pulse
  typedef enum logic [2:0] {S_IDLE, S_TOG1, S_WAIT, S_LOAD, S_ROUND, S_FIN} state_t;

  localparam logic [6:0] LAST_ROUND = 7'(ROUNDS - 1);

  state_t      r_state, w_next;
  logic [31:0] r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h;
  logic [31:0] r_win [0:15];
  logic [6:0]  r_round;
  logic [1:0]  r_wait_cnt;
  logic        r_block;
  logic        w_last, w_toggle, w_msg_wr;
  logic [31:0] w_k, w_w, w_t1, w_t2, w_s0, w_s1, w_ss0, w_ss1, w_ch, w_maj;

  function automatic logic [31:0] k_rom(input logic [5:0] idx);
    logic [31:0] k;
    k = 32'h0;
    case (idx)
      6'd0:  k = 32'h428a2f98; 6'd1:  k = 32'h71374491; 6'd2:  k = 32'hb5c0fbcf; 6'd3:  k = 32'he9b5dba5;
      6'd4:  k = 32'h3956c25b; 6'd5:  k = 32'h59f111f1; 6'd6:  k = 32'h923f82a4; 6'd7:  k = 32'hab1c5ed5;
      6'd8:  k = 32'hd807aa98; 6'd9:  k = 32'h12835b01; 6'd10: k = 32'h243185be; 6'd11: k = 32'h550c7dc3;
      6'd12: k = 32'h72be5d74; 6'd13: k = 32'h80deb1fe; 6'd14: k = 32'h9bdc06a7; 6'd15: k = 32'hc19bf174;
      6'd16: k = 32'he49b69c1; 6'd17: k = 32'hefbe4786; 6'd18: k = 32'h0fc19dc6; 6'd19: k = 32'h240ca1cc;
      6'd20: k = 32'h2de92c6f; 6'd21: k = 32'h4a7484aa; 6'd22: k = 32'h5cb0a9dc; 6'd23: k = 32'h76f988da;
      6'd24: k = 32'h983e5152; 6'd25: k = 32'ha831c66d; 6'd26: k = 32'hb00327c8; 6'd27: k = 32'hbf597fc7;
      6'd28: k = 32'hc6e00bf3; 6'd29: k = 32'hd5a79147; 6'd30: k = 32'h06ca6351; 6'd31: k = 32'h14292967;
      6'd32: k = 32'h27b70a85; 6'd33: k = 32'h2e1b2138; 6'd34: k = 32'h4d2c6dfc; 6'd35: k = 32'h53380d13;
      6'd36: k = 32'h650a7354; 6'd37: k = 32'h766a0abb; 6'd38: k = 32'h81c2c92e; 6'd39: k = 32'h92722c85;
      6'd40: k = 32'ha2bfe8a1; 6'd41: k = 32'ha81a664b; 6'd42: k = 32'hc24b8b70; 6'd43: k = 32'hc76c51a3;
      6'd44: k = 32'hd192e819; 6'd45: k = 32'hd6990624; 6'd46: k = 32'hf40e3585; 6'd47: k = 32'h106aa070;
      6'd48: k = 32'h19a4c116; 6'd49: k = 32'h1e376c08; 6'd50: k = 32'h2748774c; 6'd51: k = 32'h34b0bcb5;
      6'd52: k = 32'h391c0cb3; 6'd53: k = 32'h4ed8aa4a; 6'd54: k = 32'h5b9cca4f; 6'd55: k = 32'h682e6ff3;
      6'd56: k = 32'h748f82ee; 6'd57: k = 32'h78a5636f; 6'd58: k = 32'h84c87814; 6'd59: k = 32'h8cc70208;
      6'd60: k = 32'h90befffa; 6'd61: k = 32'ha4506ceb; 6'd62: k = 32'hbef9a3f7; 6'd63: k = 32'hc67178f2;
      default: k = 32'h0;
    endcase
    return k;
  endfunction

  assign w_last   = (r_round == LAST_ROUND);
  assign w_toggle = ((r_state == S_IDLE) && start) || ((r_state == S_ROUND) && w_last);
  assign w_k      = k_rom(r_round[5:0]);

  assign w_s0  = {r_a[1:0], r_a[31:2]} ^ {r_a[12:0], r_a[31:13]} ^ {r_a[21:0], r_a[31:22]};
  assign w_s1  = {r_e[5:0], r_e[31:6]} ^ {r_e[10:0], r_e[31:11]} ^ {r_e[24:0], r_e[31:25]};
  assign w_ch  = (r_e & r_f) ^ (~r_e & r_g);
  assign w_maj = (r_a & r_b) ^ (r_a & r_c) ^ (r_b & r_c);
  assign w_ss0 = {r_win[1][6:0], r_win[1][31:7]} ^ {r_win[1][17:0], r_win[1][31:18]} ^ {3'b000, r_win[1][31:3]};
  assign w_ss1 = {r_win[14][16:0], r_win[14][31:17]} ^ {r_win[14][18:0], r_win[14][31:19]}
               ^ {10'b0, r_win[14][31:10]};
  assign w_w   = (r_round < 7'd16) ? r_win[0] : (w_ss1 + r_win[9] + w_ss0 + r_win[0]);
  assign w_t1  = r_h + w_s1 + w_ch + w_k + w_w;
  assign w_t2  = w_s0 + w_maj;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_TOG1;
      S_TOG1:  w_next = S_WAIT;
      S_WAIT:  if (r_wait_cnt == 2'd0) w_next = S_LOAD;
      S_LOAD:  w_next = S_ROUND;
      S_ROUND: if (w_last) w_next = S_FIN;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_block    <= 1'b0;
      r_round    <= 7'd0;
      r_wait_cnt <= 2'd0;
      {r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h} <= '0;
    end else begin
      if (w_toggle) r_block <= ~r_block;
      case (r_state)
        S_TOG1: r_wait_cnt <= 2'(LOAD_WAIT - 1);
        S_WAIT: if (r_wait_cnt != 2'd0) r_wait_cnt <= r_wait_cnt - 2'd1;
        S_LOAD: begin
          {r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h} <= h_in;
          r_round <= 7'd0;
        end
        S_ROUND: begin
          r_h <= r_g; r_g <= r_f; r_f <= r_e; r_e <= r_d + w_t1;
          r_d <= r_c; r_c <= r_b; r_b <= r_a; r_a <= w_t1 + w_t2;
          r_round <= r_round + 7'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef SHA256_WRITE_GUARD_EN
  logic r_wr_err;
  assign w_msg_wr = msg_we && !busy;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          r_wr_err <= 1'b0;
    else if ((r_state == S_IDLE) && start) r_wr_err <= 1'b0;
    else if (msg_we && busy)             r_wr_err <= 1'b1;
  end
  assign wr_err = r_wr_err;
`else
  assign w_msg_wr = msg_we;
  assign wr_err   = 1'b0;
`endif

  // Window is not reset; a host write on the same edge as a shift wins its slot.
  always_ff @(posedge clk) begin
    if (r_state == S_ROUND) begin
      for (int i = 0; i < 15; i++) r_win[i] <= r_win[i+1];
      r_win[15] <= w_w;
    end
    if (w_msg_wr) r_win[msg_addr] <= msg_data;
  end

  assign block    = r_block;
  assign work_out = {r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h};
  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_FIN);

endmodule

// File: tb/tb_sha256_round_engine.sv
// Directed bench for sha256_round_engine with a behavioural H0..H7 bank driven by block.
module tb_sha256_round_engine;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         msg_we;
  logic [3:0]   msg_addr;
  logic [31:0]  msg_data;
  logic         start;
  logic [255:0] h_in;
  logic         block;
  logic [255:0] work_out;
  logic         busy;
  logic         done;
  logic         wr_err;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  always #5 clk = ~clk;

  sha256_round_engine dut (
    .clk(clk), .rst_n(rst_n), .msg_we(msg_we), .msg_addr(msg_addr), .msg_data(msg_data),
    .start(start), .h_in(h_in), .block(block), .work_out(work_out), .busy(busy),
    .done(done), .wr_err(wr_err)
  );

  // H-register bank: first toggle loads IV, second accumulates work_out.
  logic [255:0] r_bank;
  logic         r_phase, r_prev;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bank <= '0; r_phase <= 1'b0; r_prev <= 1'b0;
    end else begin
      r_prev <= block;
      if (block != r_prev) begin
        r_phase <= ~r_phase;
        if (!r_phase) r_bank <= IV;
        else for (int i = 0; i < 8; i++) r_bank[i*32 +: 32] <= r_bank[i*32 +: 32] + work_out[i*32 +: 32];
      end
    end
  end
  assign h_in = r_bank;

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic load_msg(input logic [31:0] w0);
    for (int i = 0; i < 15; i++) begin
      msg_we = 1'b1; msg_addr = 4'(i); msg_data = (i == 0) ? w0 : 32'h0;
      tick;
    end
    msg_we = 1'b0;
  endtask

  // Word 15 is written in the same cycle as start.
  task automatic do_block(input logic [31:0] w15, input int inject_n,
                          output int lat, output int edges, output logic tog1,
                          output logic b1, output logic werr1, output logic [255:0] wo,
                          output logic busy_after, output logic [255:0] h_after);
    logic pb;
    lat = -1; edges = 0; tog1 = 1'b0; b1 = 1'b0; werr1 = 1'b1; wo = '0; busy_after = 1'b1; h_after = '0;
    msg_we = 1'b1; msg_addr = 4'd15; msg_data = w15; start = 1'b1;
    pb = block;
    for (int n = 1; n <= 200; n++) begin
      tick;
      if (n == 1) begin
        start = 1'b0; msg_we = 1'b0; b1 = busy; werr1 = wr_err; tog1 = (block !== pb);
      end
      if (block !== pb) edges++;
      pb = block;
      if (n == inject_n) begin
        msg_we = 1'b1; msg_addr = 4'd3; msg_data = 32'hdeadbeef;
      end else if (n == inject_n + 1) msg_we = 1'b0;
      if (done === 1'b1) begin
        lat = n; wo = work_out;
        break;
      end
    end
    tick;
    busy_after = busy; h_after = h_in;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; msg_we = 1'b0; msg_addr = 4'd0; msg_data = 32'h0; start = 1'b0;
    tick; tick; tick;
    n_vec++; if (block !== 1'b0)     begin n_err++; $display("FAIL reset_block: got %b want 0", block); end
    n_vec++; if (work_out !== '0)    begin n_err++; $display("FAIL reset_work_out: got %h want 0", work_out); end
    n_vec++; if (busy !== 1'b0)      begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (done !== 1'b0)      begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    n_vec++; if (wr_err !== 1'b0)    begin n_err++; $display("FAIL reset_wr_err: got %b want 0", wr_err); end
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_abc;
    int lat, edges; logic tog1, b1, werr1, ba; logic [255:0] wo, ha;
    load_msg(32'h61626380);
    do_block(32'h00000018, -1, lat, edges, tog1, b1, werr1, wo, ba, ha);
    n_vec++; if (lat !== 68)   begin n_err++; $display("FAIL abc_latency: got %0d want 68", lat); end
    n_vec++; if (tog1 !== 1'b1) begin n_err++; $display("FAIL abc_first_toggle: got %b want 1", tog1); end
    n_vec++; if (b1 !== 1'b1)  begin n_err++; $display("FAIL abc_busy_rise: got %b want 1", b1); end
    n_vec++; if (edges !== 2)  begin n_err++; $display("FAIL abc_block_edges: got %0d want 2", edges); end
    n_vec++; if (wo[255:224] !== 32'h506e3058) begin n_err++; $display("FAIL abc_work_a: got %h want 506e3058", wo[255:224]); end
    n_vec++; if (wo[127:96] !== 32'h5ef50f24)  begin n_err++; $display("FAIL abc_work_e: got %h want 5ef50f24", wo[127:96]); end
    n_vec++; if (ba !== 1'b0)  begin n_err++; $display("FAIL abc_busy_fall: got %b want 0", ba); end
    n_vec++; if (ha[255:224] !== 32'hba7816bf) begin n_err++; $display("FAIL abc_H0: got %h want ba7816bf", ha[255:224]); end
    n_vec++; if (ha[127:96] !== 32'hb00361a3)  begin n_err++; $display("FAIL abc_H4: got %h want b00361a3", ha[127:96]); end
    n_vec++; if (ha[31:0] !== 32'hf20015ad)    begin n_err++; $display("FAIL abc_H7: got %h want f20015ad", ha[31:0]); end
  endtask

  task automatic test_empty;
    int lat, edges; logic tog1, b1, werr1, ba; logic [255:0] wo, ha;
    load_msg(32'h80000000);
    do_block(32'h00000000, -1, lat, edges, tog1, b1, werr1, wo, ba, ha);
    n_vec++; if (ha[255:224] !== 32'he3b0c442) begin n_err++; $display("FAIL empty_H0: got %h want e3b0c442", ha[255:224]); end
    n_vec++; if (ha[31:0] !== 32'h7852b855)    begin n_err++; $display("FAIL empty_H7: got %h want 7852b855", ha[31:0]); end
  endtask

  task automatic test_back_to_back;
    int dones, d0, d1, edges; logic pb;
    dones = 0; d0 = -1; d1 = -1; edges = 0;
    start = 1'b1; pb = block;
    for (int n = 1; n <= 260; n++) begin
      tick;
      if (n == 200) start = 1'b0;
      if (block !== pb) edges++;
      pb = block;
      if (done === 1'b1) begin
        if (dones == 0) d0 = n;
        if (dones == 1) d1 = n;
        dones++;
      end
    end
    n_vec++; if (dones !== 3)     begin n_err++; $display("FAIL b2b_done_count: got %0d want 3", dones); end
    n_vec++; if (d0 !== 68)       begin n_err++; $display("FAIL b2b_first_done: got %0d want 68", d0); end
    n_vec++; if (d1 - d0 !== 69)  begin n_err++; $display("FAIL b2b_interval: got %0d want 69", d1 - d0); end
    n_vec++; if (edges !== 6)     begin n_err++; $display("FAIL b2b_block_edges: got %0d want 6", edges); end
    n_vec++; if (busy !== 1'b0)   begin n_err++; $display("FAIL b2b_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid;
    int lat, edges; logic tog1, b1, werr1, ba; logic [255:0] wo, ha;
    load_msg(32'h61626380);
    msg_we = 1'b1; msg_addr = 4'd15; msg_data = 32'h18; start = 1'b1;
    for (int n = 1; n <= 34; n++) begin
      tick;
      if (n == 1) begin start = 1'b0; msg_we = 1'b0; end
    end
    #1 rst_n = 1'b0;
    #1;
    n_vec++; if (block !== 1'b0)  begin n_err++; $display("FAIL midrst_block: got %b want 0", block); end
    n_vec++; if (work_out !== '0) begin n_err++; $display("FAIL midrst_work_out: got %h want 0", work_out); end
    n_vec++; if (busy !== 1'b0)   begin n_err++; $display("FAIL midrst_busy: got %b want 0", busy); end
    n_vec++; if (done !== 1'b0)   begin n_err++; $display("FAIL midrst_done: got %b want 0", done); end
    tick; tick;
    rst_n = 1'b1;
    tick;
    load_msg(32'h61626380);
    do_block(32'h00000018, -1, lat, edges, tog1, b1, werr1, wo, ba, ha);
    n_vec++; if (lat !== 68) begin n_err++; $display("FAIL midrst_latency: got %0d want 68", lat); end
    n_vec++; if (ha[255:224] !== 32'hba7816bf) begin n_err++; $display("FAIL midrst_H0: got %h want ba7816bf", ha[255:224]); end
    n_vec++; if (ha[31:0] !== 32'hf20015ad)    begin n_err++; $display("FAIL midrst_H7: got %h want f20015ad", ha[31:0]); end
  endtask

  task automatic test_write_guard;
    int lat, edges; logic tog1, b1, werr1, ba; logic [255:0] wo, ha;
    load_msg(32'h61626380);
    do_block(32'h00000018, 9, lat, edges, tog1, b1, werr1, wo, ba, ha);
`ifdef SHA256_WRITE_GUARD_EN
    n_vec++; if (wr_err !== 1'b1) begin n_err++; $display("FAIL guard_wr_err_set: got %b want 1", wr_err); end
    n_vec++; if (ha[255:224] !== 32'hba7816bf) begin n_err++; $display("FAIL guard_H0: got %h want ba7816bf", ha[255:224]); end
    load_msg(32'h61626380);
    do_block(32'h00000018, -1, lat, edges, tog1, b1, werr1, wo, ba, ha);
    n_vec++; if (werr1 !== 1'b0) begin n_err++; $display("FAIL guard_wr_err_clear: got %b want 0", werr1); end
`else
    n_vec++; if (wr_err !== 1'b0) begin n_err++; $display("FAIL noguard_wr_err: got %b want 0", wr_err); end
`endif
  endtask

  initial begin
    test_reset;
    test_abc;
    test_empty;
    test_back_to_back;
    test_reset_mid;
    test_write_guard;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
